// File: rtl/right_fifo_pkg.sv
// rtl/right_fifo_pkg.sv - shared sizing helpers and flag bundle for the right-channel FIFO
package right_fifo_pkg;

    // Number of RAM words for a given address width.
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Pointer width: RAM address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

    // Status flags, all derived from the same next-state level.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/ipm_distributed_sdpram_v1_2_Right_FIFO.sv
// rtl/ipm_distributed_sdpram_v1_2_Right_FIFO.sv - distributed simple-dual-port RAM, async read
module ipm_distributed_sdpram_v1_2_Right_FIFO
    import right_fifo_pkg::*;
#(
    parameter int    ADDR_WIDTH = 4,
    parameter int    DATA_WIDTH = 16,
    parameter string RST_TYPE   = "ASYNC",
    parameter int    OUT_REG    = 0,
    parameter string INIT_FILE  = "NONE"
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = int'(fifo_depth(ADDR_WIDTH));

    // Contents are deliberately left uninitialised; reset never touches the array.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;

    // Write port: one word per enabled edge.
    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_word = mem[rd_addr];

    generate
        if (OUT_REG == 0) begin : g_comb_out
            // Combinational read; the read clock and reset only matter with an output register.
            logic unused_rd_side;
            assign unused_rd_side = &{1'b0, rd_clk, rst};
            assign rd_data = rd_word;
        end else if (RST_TYPE == "ASYNC") begin : g_reg_async
            // Registered read with asynchronous clear.
            always_ff @(posedge rd_clk or posedge rst) begin
                if (rst) begin
                    rd_data <= '0;
                end else begin
                    rd_data <= rd_word;
                end
            end
        end else begin : g_reg_sync
            // Registered read with synchronous clear.
            always_ff @(posedge rd_clk) begin
                if (rst) begin
                    rd_data <= '0;
                end else begin
                    rd_data <= rd_word;
                end
            end
        end

        // Preloading from a file is not supported by this wrapper.
        if (INIT_FILE != "NONE") begin : g_init_check
            $error("ipm_distributed_sdpram_v1_2_Right_FIFO: INIT_FILE must be NONE");
        end
    endgenerate

endmodule

// File: rtl/right_fifo_ctrl.sv
// rtl/right_fifo_ctrl.sv - single-clock FIFO controller around the right-channel distributed RAM
module right_fifo_ctrl
    import right_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int ALMOST_FULL_NUM  = int'(fifo_depth(ADDR_WIDTH)) - 2,
    parameter int ALMOST_EMPTY_NUM = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int            PW        = int'(ptr_width(ADDR_WIDTH));
    localparam logic [PW-1:0] DEPTH_LVL = PW'(fifo_depth(ADDR_WIDTH));
    localparam logic [PW-1:0] AF_LVL    = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_LVL    = PW'(ALMOST_EMPTY_NUM);
    localparam logic [PW-1:0] ONE       = PW'(1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         level_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    fifo_flags_t           flags_nxt;

    // Acceptance uses the registered flags, so a full FIFO refuses a write even
    // when a read frees a slot on the same edge (and likewise for empty).
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    ipm_distributed_sdpram_v1_2_Right_FIFO #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RST_TYPE   ("ASYNC"),
        .OUT_REG    (0),
        .INIT_FILE  ("NONE")
    ) u_ram (
        .wr_clk  (clk),
        .rd_clk  (clk),
        .rst     (~rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // Next occupancy: a simultaneous write and read cancel out.
    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + ONE;
            2'b01:   level_nxt = level - ONE;
            default: level_nxt = level;
        endcase
    end

    // Flags are decoded from the next level so they line up with level itself.
    always_comb begin
        flags_nxt              = '0;
        flags_nxt.full         = (level_nxt == DEPTH_LVL);
        flags_nxt.empty        = (level_nxt == '0);
        flags_nxt.almost_full  = (level_nxt >= AF_LVL);
        flags_nxt.almost_empty = (level_nxt <= AE_LVL);
    end

    // Pointers advance on accepted transfers and wrap modulo twice the depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    // Registered read port: rd_data only changes on an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= ram_rd_data;
            end
        end
    end

    // Registered occupancy, status flags and rejection pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            level        <= level_nxt;
            full         <= flags_nxt.full;
            empty        <= flags_nxt.empty;
            almost_full  <= flags_nxt.almost_full;
            almost_empty <= flags_nxt.almost_empty;
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_right_fifo_ctrl.sv
// tb/tb_right_fifo_ctrl.sv - directed self-checking bench for right_fifo_ctrl
module tb_right_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   level;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    right_fifo_ctrl #(
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .ALMOST_FULL_NUM  (14),
        .ALMOST_EMPTY_NUM (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (almost_empty !== 1'b1) $display("FAIL reset_almost_empty got %b want 1", almost_empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full got %b want 0", almost_full); else n_pass++;
        n_checks++; if (level !== 5'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 16'h0000) $display("FAIL reset_rd_data got %h want 0000", rd_data); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_pulses got %b%b want 00", overflow, underflow); else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = DW'(i);
            tick();
            n_checks++; if (level !== 5'(i)) $display("FAIL fill_level got %0d want %0d", level, i); else n_pass++;
            n_checks++; if (almost_full !== (i >= 14)) $display("FAIL fill_almost_full at %0d got %b want %b", i, almost_full, (i >= 14)); else n_pass++;
            n_checks++; if (almost_empty !== (i <= 2)) $display("FAIL fill_almost_empty at %0d got %b want %b", i, almost_empty, (i <= 2)); else n_pass++;
            n_checks++; if (full !== (i == 16)) $display("FAIL fill_full at %0d got %b want %b", i, full, (i == 16)); else n_pass++;
            n_checks++; if (empty !== 1'b0) $display("FAIL fill_empty at %0d got %b want 0", i, empty); else n_pass++;
        end
        wr_data = 16'h0011;
        tick();
        n_checks++; if (overflow !== 1'b1) $display("FAIL overflow_pulse got %b want 1", overflow); else n_pass++;
        n_checks++; if (level !== 5'd16) $display("FAIL overflow_level got %0d want 16", level); else n_pass++;
        wr_en = 1'b0;
        tick();
        n_checks++; if (overflow !== 1'b0) $display("FAIL overflow_clear got %b want 0", overflow); else n_pass++;
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_checks++; if (rd_valid !== 1'b1) $display("FAIL drain_rd_valid at %0d got %b want 1", i, rd_valid); else n_pass++;
            n_checks++; if (rd_data !== DW'(i)) $display("FAIL drain_rd_data got %h want %h", rd_data, DW'(i)); else n_pass++;
            n_checks++; if (level !== 5'(16 - i)) $display("FAIL drain_level got %0d want %0d", level, 16 - i); else n_pass++;
            n_checks++; if (almost_empty !== ((16 - i) <= 2)) $display("FAIL drain_almost_empty at %0d got %b", 16 - i, almost_empty); else n_pass++;
        end
        tick();
        n_checks++; if (underflow !== 1'b1) $display("FAIL underflow_pulse got %b want 1", underflow); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL underflow_rd_valid got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 16'h0010) $display("FAIL underflow_rd_data_hold got %h want 0010", rd_data); else n_pass++;
        rd_en = 1'b0;
        tick();
        n_checks++; if (underflow !== 1'b0) $display("FAIL underflow_clear got %b want 0", underflow); else n_pass++;
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = DW'(32'h100 + i);
            tick();
        end
        n_checks++; if (full !== 1'b1) $display("FAIL simul_prefill_full got %b want 1", full); else n_pass++;
        rd_en = 1'b1; wr_data = 16'hBEEF;
        tick();
        n_checks++; if (overflow !== 1'b1) $display("FAIL simul_full_overflow got %b want 1", overflow); else n_pass++;
        n_checks++; if (level !== 5'd15) $display("FAIL simul_full_level got %0d want 15", level); else n_pass++;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h0101) $display("FAIL simul_full_read got %b/%h want 1/0101", rd_valid, rd_data); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL simul_full_flag got %b want 0", full); else n_pass++;
        wr_en = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick();
            n_checks++; if (rd_data !== DW'(32'h100 + i)) $display("FAIL simul_drain_data got %h want %h", rd_data, DW'(32'h100 + i)); else n_pass++;
        end
        n_checks++; if (empty !== 1'b1) $display("FAIL simul_drain_empty got %b want 1", empty); else n_pass++;
        wr_en = 1'b1; wr_data = 16'hCAFE;
        tick();
        n_checks++; if (underflow !== 1'b1) $display("FAIL simul_empty_underflow got %b want 1", underflow); else n_pass++;
        n_checks++; if (level !== 5'd1) $display("FAIL simul_empty_level got %0d want 1", level); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0110) $display("FAIL simul_empty_read got %b/%h want 0/0110", rd_valid, rd_data); else n_pass++;
        wr_en = 1'b0;
        tick();
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hCAFE) $display("FAIL simul_empty_follow got %b/%h want 1/cafe", rd_valid, rd_data); else n_pass++;
        n_checks++; if (level !== 5'd0) $display("FAIL simul_empty_level_end got %0d want 0", level); else n_pass++;
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        wr_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_data = DW'(1000 + k);
            tick();
        end
        n_checks++; if (level !== 5'd5) $display("FAIL stream_prefill_level got %0d want 5", level); else n_pass++;
        rd_en = 1'b1;
        for (int j = 0; j < 40; j++) begin
            wr_data = DW'(1005 + j);
            tick();
            n_checks++; if (level !== 5'd5) $display("FAIL stream_level at %0d got %0d want 5", j, level); else n_pass++;
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== DW'(1000 + j)) $display("FAIL stream_data at %0d got %b/%0d want 1/%0d", j, rd_valid, rd_data, 1000 + j); else n_pass++;
        end
        wr_en = 1'b0;
        for (int j = 40; j < 45; j++) begin
            tick();
            n_checks++; if (rd_data !== DW'(1000 + j)) $display("FAIL stream_tail got %0d want %0d", rd_data, 1000 + j); else n_pass++;
        end
        rd_en = 1'b0;
        tick();
        n_checks++; if (empty !== 1'b1 || level !== 5'd0) $display("FAIL stream_end got %b/%0d want 1/0", empty, level); else n_pass++;
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_data = DW'(32'h900 + i);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_checks++; if (level !== 5'd9 || rd_valid !== 1'b1 || rd_data !== 16'h0900) $display("FAIL rstmid_pre got %0d/%b/%h want 9/1/0900", level, rd_valid, rd_data); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (level !== 5'd0) $display("FAIL rstmid_level got %0d want 0", level); else n_pass++;
        n_checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) $display("FAIL rstmid_empty got %b%b want 11", empty, almost_empty); else n_pass++;
        n_checks++; if (full !== 1'b0 || almost_full !== 1'b0) $display("FAIL rstmid_full got %b%b want 00", full, almost_full); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rstmid_rd_valid got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 16'h0000) $display("FAIL rstmid_rd_data got %h want 0000", rd_data); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        wr_en = 1'b1; wr_data = 16'hABCD;
        tick();
        wr_en = 1'b0;
        n_checks++; if (level !== 5'd1) $display("FAIL rstmid_new_level got %0d want 1", level); else n_pass++;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hABCD) $display("FAIL rstmid_new_data got %b/%h want 1/abcd", rd_valid, rd_data); else n_pass++;
        n_checks++; if (level !== 5'd0 || empty !== 1'b1) $display("FAIL rstmid_new_empty got %0d/%b want 0/1", level, empty); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_stream();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/right_fifo_ctrl.md
# right_fifo_ctrl

Single-clock synchronous FIFO that wraps the distributed simple-dual-port RAM and supplies the logic the RAM lacks: write and read pointers, occupancy, status flags and an enabled, registered read port. It sits between a line-data producer and a consumer in the right-channel video path, replacing ad-hoc address generation around the bare RAM.

## Interface
- ADDR_WIDTH, 4: RAM address width, 4–10; depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 16: word width, 1–256.
- ALMOST_FULL_NUM, 2**ADDR_WIDTH-2: almost_full asserts when level >= this value.
- ALMOST_EMPTY_NUM, 2: almost_empty asserts when level <= this value.

- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  registered read word.
- rd_valid  out  1  rd_data holds a newly popped word this cycle.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= ALMOST_FULL_NUM.
- almost_empty  out  1  level <= ALMOST_EMPTY_NUM.
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: wr_en rejected because full.
- underflow  out  1  one-cycle pulse: rd_en rejected because empty.

## Operation
- Pointers wr_ptr, rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address the RAM. The MSB is a wrap bit. Both wrap naturally modulo 2*DEPTH.
- Write accepted iff wr_en && !full, where full is the registered value in the current cycle. An accepted write stores wr_data at wr_ptr[ADDR_WIDTH-1:0] and increments wr_ptr.
- Read accepted iff rd_en && !empty, where empty is the registered value in the current cycle. An accepted read captures the RAM output at rd_ptr into rd_data, increments rd_ptr, and sets rd_valid for the next cycle.
- rd_data holds its value when no read is accepted. It is never cleared by a rejected read.
- Level update: +1 for a write only, -1 for a read only, unchanged when both or neither are accepted.
- Simultaneous events:
  - When full and both requested, only the read is accepted and overflow pulses.
  - When empty and both requested, only the write is accepted and underflow pulses.
  - Otherwise both are accepted and level is unchanged.
- All flags and level are registered and computed from the next-state level, so they are valid in the cycle after the causing edge.
- Reset values: rd_data 0, rd_valid 0, full 0, empty 1, almost_full 0, almost_empty 1, level 0, overflow 0, underflow 0, both pointers 0. RAM contents are not cleared by reset.
- Reset asserted mid-operation immediately forces the reset values. Any data in the RAM is discarded logically.

## Timing
- Write at edge N: empty deasserts and level increments, visible after N.
- rd_en asserted in cycle N+1 is accepted at edge N+1; rd_data and rd_valid are valid after N+1. Minimum write-to-data latency is 2 edges.
- Read latency is 1 cycle from an accepted rd_en to rd_data/rd_valid.
- A continuous rd_en on a non-empty FIFO sustains one word per cycle.
- A location freed by a read at edge N may be rewritten at edge N+1 without corrupting data.

## Structure
- Shared package right_fifo_pkg holds the DEPTH function (2**ADDR_WIDTH) and the pointer-width constant helper.
- One sub-module: ipm_distributed_sdpram_v1_2_Right_FIFO, instantiated with:
  - wr_clk = rd_clk = clk
  - rst = ~rst_n
  - RST_TYPE "ASYNC", OUT_REG 0, INIT_FILE "NONE"
  - wr_en = accepted write
- All output registering is done in right_fifo_ctrl.

## Test plan
- Reset, then idle: empty=1, almost_empty=1, full=0, level=0, rd_valid=0, rd_data=0.
- ADDR_WIDTH=4: write 0x0001..0x0010 on consecutive cycles. full asserts after the 16th write; a 17th wr_en pulses overflow and level stays 16. Read 16 times: rd_data returns 0x0001..0x0010 in order, with rd_valid high each cycle.
- Level 16 with wr_en and rd_en high together: only the read is accepted, overflow=1, level=15. At level 0 with both high: only the write is accepted, underflow=1, level=1.
- Steady stream of 40 words with simultaneous read/write at level 5: level stays 5 throughout, pointers wrap at least twice, and the data sequence is intact.
- Flag thresholds with ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2: almost_full rises the cycle after level reaches 14; almost_empty falls the cycle after level reaches 3.
- rst_n pulsed low with level 9: all outputs return to reset values asynchronously. A subsequent write then read returns the new word, not stale data.
